// File: rtl/ts_pkg.sv
// Shared definitions for the EP3 transport-stream packer: FSM states,
// TS framing constants and the endpoint transfer limit.
package ts_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_FILL,
    ST_COMMIT,
    ST_ACK_WAIT
  } state_t;

  localparam int         TS_PKT_LEN   = 188;
  localparam logic [7:0] TS_SYNC      = 8'h47;
  localparam int         EP3_MAX_XFER = 1024;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/ts_sat_cnt.sv
// 16-bit event counter that sticks at all-ones; cleared only by reset.
module ts_sat_cnt
  import ts_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= sat_inc(count_reg);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/ts_ep3_packer.sv
// Aligns a byte-wide MPEG-TS stream to packets and packs whole packets into
// the EP3 endpoint buffer. Optional idle flush: define TS_EP3_PACKER_FLUSH_EN.
module ts_ep3_packer
  import ts_pkg::*;
#(
  parameter int         PKT_LEN       = TS_PKT_LEN,
  parameter int         PKTS_PER_XFER = 5,
  parameter int         ADDR_W        = 11,
  parameter logic [7:0] SYNC_BYTE     = TS_SYNC
`ifdef TS_EP3_PACKER_FLUSH_EN
  ,
  parameter logic [15:0] TIMEOUT_CYC  = 16'd50000
`endif
) (
  input  logic              ext_clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [7:0]        ts_data,
  input  logic              ts_valid,
  input  logic              ts_sop,
  output logic [ADDR_W-1:0] buf_in_addr,
  output logic [7:0]        buf_in_data,
  output logic              buf_in_wren,
  input  logic              buf_in_ready,
  output logic              buf_in_commit,
  output logic [10:0]       buf_in_commit_len,
  input  logic              buf_in_commit_ack,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       sync_err_cnt,
  output logic              busy
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [7:0]        byte_cnt_reg, byte_cnt_next;
  logic [3:0]        pkt_cnt_reg, pkt_cnt_next;
  logic              commit_reg, commit_next;
  logic [10:0]       commit_len_reg, commit_len_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        data_reg;
  logic              wren_reg;

  logic              do_write;
  logic [ADDR_W-1:0] write_at;
  logic              drop_inc;
  logic              sync_inc;

  logic              sop_v;
  logic              sync_ok;
  logic              last_byte;
  logic              last_pkt;
  logic [ADDR_W-1:0] pkt_end;

`ifdef TS_EP3_PACKER_FLUSH_EN
  logic [15:0]       idle_reg, idle_next;
`endif

  assign sop_v     = ts_valid & ts_sop;
  assign sync_ok   = (ts_data == SYNC_BYTE);
  assign last_byte = (byte_cnt_reg == 8'(PKT_LEN - 1));
  assign last_pkt  = (pkt_cnt_reg == 4'(PKTS_PER_XFER - 1));
  assign pkt_end   = base_reg + ADDR_W'(PKT_LEN);

  always_comb begin
    state_next      = state_reg;
    base_next       = base_reg;
    byte_cnt_next   = byte_cnt_reg;
    pkt_cnt_next    = pkt_cnt_reg;
    commit_next     = commit_reg;
    commit_len_next = commit_len_reg;
    do_write        = 1'b0;
    write_at        = base_reg;
    drop_inc        = 1'b0;
    sync_inc        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        drop_inc = sop_v;
        if (enable && buf_in_ready) begin
          state_next    = ST_HUNT;
          base_next     = '0;
          byte_cnt_next = '0;
          pkt_cnt_next  = '0;
        end
      end

      ST_HUNT: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (sop_v) begin
          if (sync_ok) begin
            do_write      = 1'b1;
            byte_cnt_next = 8'd1;
            state_next    = ST_FILL;
          end else begin
            sync_inc = 1'b1;
          end
        end
      end

      ST_FILL: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (ts_valid) begin
          if (ts_sop || byte_cnt_reg == 8'd0) begin
            // Any sop or boundary byte rewinds to the current packet start;
            // only a good sop exactly at a boundary is error-free.
            sync_inc      = (byte_cnt_reg != 8'd0) || !(ts_sop && sync_ok);
            byte_cnt_next = '0;
            if (ts_sop && sync_ok) begin
              do_write      = 1'b1;
              byte_cnt_next = 8'd1;
            end else begin
              state_next = ST_HUNT;
            end
          end else begin
            do_write = 1'b1;
            write_at = base_reg + ADDR_W'(byte_cnt_reg);
            if (last_byte) begin
              byte_cnt_next = '0;
              base_next     = pkt_end;
              pkt_cnt_next  = pkt_cnt_reg + 4'd1;
              if (last_pkt) begin
                state_next      = ST_COMMIT;
                commit_next     = 1'b1;
                commit_len_next = 11'(pkt_end);
              end
            end else begin
              byte_cnt_next = byte_cnt_reg + 8'd1;
            end
          end
        end
      end

      ST_COMMIT: begin
        drop_inc = sop_v;
        if (buf_in_commit_ack) begin
          commit_next = 1'b0;
          state_next  = ST_ACK_WAIT;
        end
      end

      ST_ACK_WAIT: begin
        drop_inc = sop_v;
        if (!buf_in_commit_ack) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

`ifdef TS_EP3_PACKER_FLUSH_EN
    // Idle cycles only count once something worth committing exists.
    idle_next = '0;
    if ((state_reg == ST_HUNT || state_reg == ST_FILL) && enable &&
        pkt_cnt_reg != 4'd0 && !ts_valid) begin
      idle_next = idle_reg + 16'd1;
      if (idle_next == TIMEOUT_CYC) begin
        state_next      = ST_COMMIT;
        commit_next     = 1'b1;
        commit_len_next = 11'(base_reg);
        byte_cnt_next   = '0;
      end
    end
`endif
  end

  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      base_reg       <= '0;
      byte_cnt_reg   <= '0;
      pkt_cnt_reg    <= '0;
      commit_reg     <= 1'b0;
      commit_len_reg <= '0;
      addr_reg       <= '0;
      data_reg       <= '0;
      wren_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      base_reg       <= base_next;
      byte_cnt_reg   <= byte_cnt_next;
      pkt_cnt_reg    <= pkt_cnt_next;
      commit_reg     <= commit_next;
      commit_len_reg <= commit_len_next;
      wren_reg       <= do_write;
      if (do_write) begin
        addr_reg <= write_at;
        data_reg <= ts_data;
      end
    end
  end

`ifdef TS_EP3_PACKER_FLUSH_EN
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_reg <= '0;
    end else begin
      idle_reg <= idle_next;
    end
  end
`endif

  // Index 0 counts dropped packets, index 1 counts framing errors.
  logic [1:0]  cnt_inc;
  logic [15:0] cnt_val [2];

  assign cnt_inc = {sync_inc, drop_inc};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    ts_sat_cnt u_cnt (
      .clk   (ext_clk),
      .rst_n (reset_n),
      .inc   (cnt_inc[gi]),
      .count (cnt_val[gi])
    );
  end

  assign buf_in_addr       = addr_reg;
  assign buf_in_data       = data_reg;
  assign buf_in_wren       = wren_reg;
  assign buf_in_commit     = commit_reg;
  assign buf_in_commit_len = commit_len_reg;
  assign drop_cnt          = cnt_val[0];
  assign sync_err_cnt      = cnt_val[1];
  assign busy              = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ts_ep3_packer.sv
// Randomized directed bench for ts_ep3_packer: good packets are queued as the
// expected buffer image; framing noise and drops are tallied per event.
module tb_ts_ep3_packer;

  logic        ext_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  ts_data = 8'h00;
  logic        ts_valid = 1'b0;
  logic        ts_sop = 1'b0;
  logic        buf_in_ready = 1'b0;
  logic        buf_in_commit_ack = 1'b0;
  logic [10:0] buf_in_addr;
  logic [7:0]  buf_in_data;
  logic        buf_in_wren;
  logic        buf_in_commit;
  logic [10:0] buf_in_commit_len;
  logic [15:0] drop_cnt;
  logic [15:0] sync_err_cnt;
  logic        busy;

  ts_ep3_packer #(
    .PKT_LEN(188)
`ifdef TS_EP3_PACKER_FLUSH_EN
    , .TIMEOUT_CYC(16'd100)
`endif
  ) dut (
    .ext_clk           (ext_clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .ts_data           (ts_data),
    .ts_valid          (ts_valid),
    .ts_sop            (ts_sop),
    .buf_in_addr       (buf_in_addr),
    .buf_in_data       (buf_in_data),
    .buf_in_wren       (buf_in_wren),
    .buf_in_ready      (buf_in_ready),
    .buf_in_commit     (buf_in_commit),
    .buf_in_commit_len (buf_in_commit_len),
    .buf_in_commit_ack (buf_in_commit_ack),
    .drop_cnt          (drop_cnt),
    .sync_err_cnt      (sync_err_cnt),
    .busy              (busy)
  );

  always #5 ext_clk = ~ext_clk;

  int checks = 0;
  int failures = 0;
  int exp_drop = 0;
  int exp_sync = 0;
  logic [7:0] exp_q[$];

  // Endpoint buffer model: each write is tagged with the transfer it belongs to.
  int mem_data [2048];
  int mem_gen  [2048];
  int cur_gen = 0;
  int wr_count = 0;

  always @(negedge ext_clk) begin
    if (buf_in_wren === 1'b1) begin
      mem_data[buf_in_addr] = int'(buf_in_data);
      mem_gen[buf_in_addr]  = cur_gen;
      wr_count++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation hung");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge ext_clk);
      #1;
    end
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic sop);
    int gap;
    gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
    ts_valid = 1'b0;
    ts_sop   = 1'b0;
    cyc(gap);
    ts_data  = d;
    ts_sop   = sop;
    ts_valid = 1'b1;
    cyc(1);
    ts_valid = 1'b0;
    ts_sop   = 1'b0;
    ts_data  = 8'($urandom);
  endtask

  task automatic send_pkt(input logic [7:0] first, input int len, input bit keep,
                          input bit chk_first);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = (i == 0) ? first : 8'($urandom);
      if (keep) exp_q.push_back(b);
      drive_byte(b, i == 0);
      if (i == 0 && chk_first) begin
        check("first_wren", 32'(buf_in_wren), 32'd1);
        check("first_addr", 32'(buf_in_addr), 32'd0);
        check("first_data", 32'(buf_in_data), 32'h47);
      end
    end
  endtask

  function automatic logic [7:0] bad_sync();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'h47) b = 8'h46;
    return b;
  endfunction

  task automatic new_xfer();
    cur_gen++;
    exp_q.delete();
  endtask

  task automatic wait_commit(input string tag, output int n);
    n = 0;
    while (buf_in_commit !== 1'b1 && n < 3000) begin
      cyc(1);
      n++;
    end
    check({tag, "_commit"}, 32'(buf_in_commit), 32'd1);
  endtask

  task automatic check_image(input string tag);
    int mism;
    mism = 0;
    cyc(1);
    check({tag, "_len"}, 32'(buf_in_commit_len), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (mem_gen[i] != cur_gen || mem_data[i] != int'(exp_q[i])) mism++;
    end
    check({tag, "_image_mism"}, 32'(mism), 32'd0);
    check({tag, "_sync_cnt"}, 32'(sync_err_cnt), 32'(exp_sync));
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
  endtask

  task automatic check_xfer(input string tag);
    int n;
    wait_commit(tag, n);
    check_image(tag);
  endtask

  task automatic ack_pulse(input string tag);
    buf_in_commit_ack = 1'b1;
    cyc(1);
    check({tag, "_commit_low"}, 32'(buf_in_commit), 32'd0);
    check({tag, "_busy_ackwait"}, 32'(busy), 32'd1);
    buf_in_commit_ack = 1'b0;
    cyc(1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int wc;
    int n;
    int ev;

    // Reset state
    ts_data = 8'($urandom);
    cyc(3);
    check("rst_addr", 32'(buf_in_addr), 32'd0);
    check("rst_data", 32'(buf_in_data), 32'd0);
    check("rst_wren", 32'(buf_in_wren), 32'd0);
    check("rst_commit", 32'(buf_in_commit), 32'd0);
    check("rst_len", 32'(buf_in_commit_len), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_sync", 32'(sync_err_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    cyc(1);

    // Clean stream of five packets
    enable = 1'b1;
    buf_in_ready = 1'b1;
    new_xfer();
    cyc(2);
    wc = wr_count;
    for (int p = 0; p < 5; p++) send_pkt(8'h47, 188, 1'b1, p == 0);
    check_xfer("clean");
    check("clean_wr_count", 32'(wr_count - wc), 32'd940);
    enable = 1'b0;
    ack_pulse("clean");
    cyc(3);
    check("disabled_idle", 32'(busy), 32'd0);
    wc = wr_count;
    send_pkt(8'h47, 188, 1'b0, 1'b0);
    exp_drop++;
    check("idle_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    check("idle_no_wren", 32'(wr_count - wc), 32'd0);
    enable = 1'b1;
    cyc(2);

    // Bad sync in HUNT, then a mid-packet sop at byte 100 of packet 2
    new_xfer();
    wc = wr_count;
    send_pkt(8'h46, 188, 1'b0, 1'b0);
    exp_sync++;
    check("badsync_cnt", 32'(sync_err_cnt), 32'(exp_sync));
    check("badsync_no_wren", 32'(wr_count - wc), 32'd0);
    check("badsync_hunting", 32'(busy), 32'd1);
    send_pkt(8'h47, 188, 1'b1, 1'b1);
    send_pkt(8'h47, 188, 1'b1, 1'b0);
    send_pkt(8'h47, 100, 1'b0, 1'b0);
    exp_sync++;
    for (int p = 2; p < 5; p++) send_pkt(8'h47, 188, 1'b1, 1'b0);
    check_xfer("midsop");
    ack_pulse("midsop");
    cyc(2);

    // Randomized framing noise between good packets
    for (int t = 0; t < 3; t++) begin
      new_xfer();
      for (int p = 0; p < 5; p++) begin
        send_pkt(8'h47, 188, 1'b1, 1'b0);
        if (p < 4) begin
          ev = int'($urandom_range(0, 2));
          if (ev == 0) begin
            send_pkt(8'h47, int'($urandom_range(1, 187)), 1'b0, 1'b0);
          end else if (ev == 1) begin
            n = int'($urandom_range(1, 3));
            for (int k = 0; k < n; k++) drive_byte(8'($urandom), 1'b0);
          end else begin
            send_pkt(bad_sync(), 188, 1'b0, 1'b0);
          end
          exp_sync++;
        end
      end
      check_xfer("noise");
      ack_pulse("noise");
      cyc(2);
    end

    // Backpressure: ack withheld for three packet times
    new_xfer();
    for (int p = 0; p < 5; p++) send_pkt(8'h47, 188, 1'b1, 1'b0);
    check_xfer("bp");
    wc = wr_count;
    for (int p = 0; p < 3; p++) send_pkt(8'h47, 188, 1'b0, 1'b0);
    exp_drop += 3;
    check("bp_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    check("bp_no_wren", 32'(wr_count - wc), 32'd0);
    check("bp_commit_held", 32'(buf_in_commit), 32'd1);
    ack_pulse("bp");
    cyc(2);
    new_xfer();
    for (int p = 0; p < 5; p++) send_pkt(8'h47, 188, 1'b1, 1'b0);
    check_xfer("bp_resume");
    ack_pulse("bp_resume");
    cyc(2);

    // Enable dropped mid-fill discards the partial transfer
    new_xfer();
    send_pkt(8'h47, 188, 1'b0, 1'b0);
    send_pkt(8'h47, 188, 1'b0, 1'b0);
    send_pkt(8'h47, 50, 1'b0, 1'b0);
    enable = 1'b0;
    cyc(2);
    check("dis_fill_busy", 32'(busy), 32'd0);
    check("dis_fill_commit", 32'(buf_in_commit), 32'd0);
    enable = 1'b1;
    cyc(2);
    new_xfer();
    for (int p = 0; p < 5; p++) send_pkt(8'h47, 188, 1'b1, p == 0);
    check_xfer("dis_refill");

    // Asynchronous reset while committing
    @(posedge ext_clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_commit", 32'(buf_in_commit), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_drop", 32'(drop_cnt), 32'd0);
    check("arst_sync", 32'(sync_err_cnt), 32'd0);
    check("arst_len", 32'(buf_in_commit_len), 32'd0);
    exp_drop = 0;
    exp_sync = 0;
    cyc(1);
    reset_n = 1'b1;
    cyc(3);

    // Two packets plus a partial, then silence
    new_xfer();
    send_pkt(8'h47, 188, 1'b1, 1'b0);
    send_pkt(8'h47, 188, 1'b1, 1'b0);
    send_pkt(8'h47, 50, 1'b0, 1'b0);
`ifdef TS_EP3_PACKER_FLUSH_EN
    wait_commit("flush", n);
    check("flush_idle_cycles", 32'(n), 32'd100);
    check_image("flush");
    ack_pulse("flush");
`else
    cyc(300);
    check("noflush_commit", 32'(buf_in_commit), 32'd0);
    check("noflush_busy", 32'(busy), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
